operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Pipeline stage directly upstream of the execute (ALU/Process) stage of the 8051 core.
- Accepts one decoded instruction at a time and resolves its source operand from immediate, direct, register-bank, indirect (@R0/@R1) or bit addressing.
- Reads operands through a synchronous internal-RAM/SFR read port.
- Presents a_data, b_data, bit_location, alu_op, instruction and psw to execute under a valid/ready handshake.

Parameters:
- RAM_LAT, 1, read latency of the RAM port in cycles. Fixed at 1; other values are not supported.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort (taken branch); drops the in-flight instruction
- in_valid  input  1  decoder has an instruction
- in_ready  output  1  stage can accept; equals (state==IDLE)
- instruction_in  input  8  opcode
- operand_in  input  8  second instruction byte (immediate, direct address or bit address)
- src_mode  input  3  addressing mode: NONE=0, IMM=1, DIR=2, IND=3, REG=4, BIT=5
- alu_op_in  input  4  ALU operation code; passed through unchanged
- acc_in  input  8  current ACC
- b_reg_in  input  8  current B register
- psw_in  input  8  current PSW; bits [4:3] give the register bank
- ram_rd_en  output  1  read strobe
- ram_addr  output  8  read address
- ram_sfr  output  1  1 = SFR space (direct address ≥0x80), 0 = IRAM
- ram_rdata  input  8  read data, valid the cycle after ram_rd_en
- out_valid  output  1  operands ready for execute
- out_ready  input  1  execute consumes
- a_data  output  8  ACC captured at accept
- b_data  output  8  resolved source operand
- bit_location  output  3  bit index for BIT mode, else 0
- alu_op  output  4  registered alu_op_in
- instruction  output  8  registered opcode
- psw_out  output  8  PSW captured at accept
- operand_addr  output  8  resolved byte address, used for writeback

Behaviour:
- Reset: state=IDLE. All outputs are 0 except in_ready=1. Reset is asynchronous and aborts any in-flight fetch, including a read that is in progress.
- Accept cycle T: in_valid && in_ready. Capture instruction_in, operand_in, src_mode, alu_op_in, acc_in, psw_in.
- States: IDLE, RD_PTR, WT_PTR, RD_DAT, WT_DAT, HOLD.
- NONE: b_data=0. IMM: b_data=operand_in. Both go IDLE→HOLD; out_valid at T+1.
- DIR with address 0xE0/0xF0/0xD0: bypass with no RAM read. b_data = acc_in, b_reg_in or psw_in respectively, all captured at T. IDLE→HOLD; out_valid at T+1.
- Other DIR, REG and BIT: IDLE→RD_DAT→WT_DAT→HOLD.
  - ram_rd_en=1 in RD_DAT.
  - b_data captured from ram_rdata at the end of WT_DAT.
  - out_valid at T+3.
- REG address: {3'b000, psw[4:3], opcode[2:0]}.
- BIT address mapping:
  - bit address <0x80: byte address = 0x20 + addr[6:3].
  - otherwise: byte address = {addr[7:3], 3'b000}.
  - bit_location = addr[2:0].
  - ram_sfr = addr[7].
- IND: IDLE→RD_PTR→WT_PTR→RD_DAT→WT_DAT→HOLD.
  - RD_PTR reads Ri at {3'b000, psw[4:3], 2'b00, opcode[0]}.
  - WT_PTR captures the pointer.
  - RD_DAT reads IRAM[pointer] with ram_sfr=0, even when pointer ≥0x80.
  - out_valid at T+5.
- operand_addr holds the resolved byte address for DIR, REG, BIT and IND modes, and is 0 otherwise.
- ram_rd_en is 0 in every state other than RD_PTR and RD_DAT. ram_addr and ram_sfr hold their last value when ram_rd_en is 0.
- HOLD: out_valid=1, and outputs are stable until out_ready. On the handshake the stage goes to IDLE (no same-cycle re-accept), so peak throughput is one instruction per 2 cycles.
- flush takes priority over every other event in every state:
  - Next state is IDLE and out_valid=0 the following cycle.
  - A pending RAM read is discarded, and ram_rdata is ignored on the next cycle.
  - flush in IDLE together with in_valid: nothing is accepted.
- Invalid src_mode (6, 7) is treated as NONE.
- Inputs are sampled only in the accept cycle. Later changes to acc_in or psw_in do not affect the in-flight instruction.

Decomposition:
- mcu51_pkg holds:
  - src_mode encodings
  - SFR address constants: ACC=0xE0, B=0xF0, PSW=0xD0
  - bit-area base 0x20
  - FSM state encoding
- One combinational sub-module, bit_addr_map: maps an 8-bit bit address to {byte address, bit index, sfr flag}.

Test Plan:
- IMM: opcode 0x24, operand 0x5A, acc 0x11. out_valid at T+1 with a_data=0x11, b_data=0x5A, operand_addr=0; no ram_rd_en.
- REG: opcode 0x2B (R3), psw=0x10 (bank 2), RAM[0x13]=0x7E. ram_addr=0x13 at T+1; b_data=0x7E and out_valid at T+3.
- IND: opcode 0x27 (@R1), psw=0x08, RAM[0x09]=0x90, IRAM[0x90]=0x3C. Reads of 0x09 then 0x90 with ram_sfr=0; b_data=0x3C at T+5.
- BIT 0x2F → ram_addr 0x25, bit_location 7. BIT 0xE3 → ram_addr 0xE0, ram_sfr=1, bit_location 3.
- DIR 0xF0 with b_reg_in=0xA5: no read, b_data=0xA5 at T+1. Hold out_ready=0 for 4 cycles: outputs stable, in_ready=0.
- flush asserted in WT_PTR of an IND fetch: out_valid stays 0, stage is IDLE next cycle, and a new IMM instruction is accepted and completes normally. rst_n pulsed during RD_DAT: all outputs 0 immediately.

Source files
------------

// File: rtl/mcu51_pkg.sv
// Shared definitions for the 8051 operand fetch stage: addressing-mode
// encodings, well-known SFR addresses and the fetch FSM state encoding.
package mcu51_pkg;

  // Source addressing modes as delivered by the decoder
  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_IMM  = 3'd1,
    SRC_DIR  = 3'd2,
    SRC_IND  = 3'd3,
    SRC_REG  = 3'd4,
    SRC_BIT  = 3'd5
  } src_mode_e;

  // Operand fetch sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_PTR = 3'd1,
    ST_WT_PTR = 3'd2,
    ST_RD_DAT = 3'd3,
    ST_WT_DAT = 3'd4,
    ST_HOLD   = 3'd5
  } fetch_state_e;

  // SFRs whose live values arrive on dedicated inputs, so no RAM read is needed
  localparam logic [7:0] SFR_ACC = 8'hE0;
  localparam logic [7:0] SFR_B   = 8'hF0;
  localparam logic [7:0] SFR_PSW = 8'hD0;

  // First byte of the bit-addressable internal RAM area
  localparam logic [7:0] BIT_AREA_BASE = 8'h20;

  // Encodings 6 and 7 are unused by the decoder and behave like NONE
  function automatic src_mode_e decode_src_mode(input logic [2:0] raw);
    case (raw)
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5: return src_mode_e'(raw);
      default:                      return SRC_NONE;
    endcase
  endfunction

  // Byte address of register R<idx> in the bank selected by PSW.RS1:RS0
  function automatic logic [7:0] bank_reg_addr(input logic [7:0] psw,
                                               input logic [2:0] idx);
    return {3'b000, psw[4:3], idx};
  endfunction

endpackage

// File: rtl/bit_addr_map.sv
// Maps an 8051 bit address onto the byte that holds it. Bit addresses
// below 0x80 live in the 0x20..0x2F RAM area; the rest are bits of the
// SFRs whose address is a multiple of 8.
module bit_addr_map
  import mcu51_pkg::*;
(
  input  logic [7:0] bit_addr,
  output logic [7:0] byte_addr,
  output logic [2:0] bit_index,
  output logic       is_sfr
);

  // Pure address arithmetic, no state
  always_comb begin
    bit_index = bit_addr[2:0];
    is_sfr    = bit_addr[7];
    if (bit_addr[7]) begin
      byte_addr = {bit_addr[7:3], 3'b000};
    end else begin
      byte_addr = BIT_AREA_BASE + {4'b0000, bit_addr[6:3]};
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage of the 8051 core. Takes one decoded instruction,
// resolves its source operand (immediate, direct, register, indirect or
// bit addressing) through a 1-cycle RAM/SFR read port, and presents the
// operands to execute under a valid/ready handshake.
module operand_fetch
  import mcu51_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] instruction_in,
  input  logic [7:0] operand_in,
  input  logic [2:0] src_mode,
  input  logic [3:0] alu_op_in,
  input  logic [7:0] acc_in,
  input  logic [7:0] b_reg_in,
  input  logic [7:0] psw_in,
  output logic       ram_rd_en,
  output logic [7:0] ram_addr,
  output logic       ram_sfr,
  input  logic [7:0] ram_rdata,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] a_data,
  output logic [7:0] b_data,
  output logic [2:0] bit_location,
  output logic [3:0] alu_op,
  output logic [7:0] instruction,
  output logic [7:0] psw_out,
  output logic [7:0] operand_addr
);

  // The WT_* states assume read data arrives exactly one cycle after the strobe
  if (RAM_LAT != 1) begin : g_bad_ram_lat
    $error("operand_fetch only supports RAM_LAT == 1");
  end

  fetch_state_e state_q;
  fetch_state_e state_d;
  src_mode_e    mode;

  logic       accept;
  logic       load_ptr;
  logic       load_data;

  logic [7:0] bit_byte_addr;
  logic [2:0] bit_idx;
  logic       bit_sfr;

  fetch_state_e res_next;
  logic [7:0]   res_b;
  logic [7:0]   res_op_addr;
  logic [2:0]   res_bit;
  logic         res_rd_load;
  logic [7:0]   res_rd_addr;
  logic         res_rd_sfr;

  assign mode = decode_src_mode(src_mode);

  bit_addr_map u_bit_map (
    .bit_addr  (operand_in),
    .byte_addr (bit_byte_addr),
    .bit_index (bit_idx),
    .is_sfr    (bit_sfr)
  );

  // Work out, from the instruction on the inputs, everything captured on accept
  always_comb begin
    res_next    = ST_HOLD;
    res_b       = 8'h00;
    res_op_addr = 8'h00;
    res_bit     = 3'd0;
    res_rd_load = 1'b0;
    res_rd_addr = 8'h00;
    res_rd_sfr  = 1'b0;
    case (mode)
      SRC_IMM: begin
        res_b = operand_in;
      end
      SRC_DIR: begin
        res_op_addr = operand_in;
        if (operand_in == SFR_ACC) begin
          res_b = acc_in;
        end else if (operand_in == SFR_B) begin
          res_b = b_reg_in;
        end else if (operand_in == SFR_PSW) begin
          res_b = psw_in;
        end else begin
          res_next    = ST_RD_DAT;
          res_rd_load = 1'b1;
          res_rd_addr = operand_in;
          res_rd_sfr  = operand_in[7];
        end
      end
      SRC_REG: begin
        res_next    = ST_RD_DAT;
        res_rd_load = 1'b1;
        res_rd_addr = bank_reg_addr(psw_in, instruction_in[2:0]);
        res_op_addr = bank_reg_addr(psw_in, instruction_in[2:0]);
      end
      SRC_BIT: begin
        res_next    = ST_RD_DAT;
        res_rd_load = 1'b1;
        res_rd_addr = bit_byte_addr;
        res_rd_sfr  = bit_sfr;
        res_op_addr = bit_byte_addr;
        res_bit     = bit_idx;
      end
      SRC_IND: begin
        // The pointer register is always read from IRAM; the final
        // operand address is only known once the pointer comes back.
        res_next    = ST_RD_PTR;
        res_rd_load = 1'b1;
        res_rd_addr = bank_reg_addr(psw_in, {2'b00, instruction_in[0]});
      end
      default: begin
        res_b = 8'h00;
      end
    endcase
  end

  // State register; reset aborts any fetch in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing and datapath load strobes; flush overrides everything
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    load_ptr  = 1'b0;
    load_data = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            accept  = 1'b1;
            state_d = res_next;
          end
        end
        ST_RD_PTR: state_d = ST_WT_PTR;
        ST_WT_PTR: begin
          load_ptr = 1'b1;
          state_d  = ST_RD_DAT;
        end
        ST_RD_DAT: state_d = ST_WT_DAT;
        ST_WT_DAT: begin
          load_data = 1'b1;
          state_d   = ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign ram_rd_en = (state_q == ST_RD_PTR) || (state_q == ST_RD_DAT);

  // Read port address: set on accept, then retargeted to the pointer for @Ri
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr <= 8'h00;
      ram_sfr  <= 1'b0;
    end else if (accept && res_rd_load) begin
      ram_addr <= res_rd_addr;
      ram_sfr  <= res_rd_sfr;
    end else if (load_ptr) begin
      ram_addr <= ram_rdata;
      ram_sfr  <= 1'b0;
    end
  end

  // Execute-facing operand registers, held steady while waiting in HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data       <= 8'h00;
      b_data       <= 8'h00;
      bit_location <= 3'd0;
      alu_op       <= 4'h0;
      instruction  <= 8'h00;
      psw_out      <= 8'h00;
      operand_addr <= 8'h00;
    end else if (accept) begin
      a_data       <= acc_in;
      b_data       <= res_b;
      bit_location <= res_bit;
      alu_op       <= alu_op_in;
      instruction  <= instruction_in;
      psw_out      <= psw_in;
      operand_addr <= res_op_addr;
    end else if (load_ptr) begin
      operand_addr <= ram_rdata;
    end else if (load_data) begin
      b_data       <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized
// instructions checked against a behavioural model of operand resolution.
module tb_operand_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] instruction_in;
  logic [7:0] operand_in;
  logic [2:0] src_mode;
  logic [3:0] alu_op_in;
  logic [7:0] acc_in;
  logic [7:0] b_reg_in;
  logic [7:0] psw_in;
  logic       ram_rd_en;
  logic [7:0] ram_addr;
  logic       ram_sfr;
  logic [7:0] ram_rdata;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] a_data;
  logic [7:0] b_data;
  logic [2:0] bit_location;
  logic [3:0] alu_op;
  logic [7:0] instruction;
  logic [7:0] psw_out;
  logic [7:0] operand_addr;

  int checks = 0;
  int errors = 0;

  logic [7:0] iram [256];
  logic [7:0] sfrm [256];

  int         obs_lat;
  int         obs_rd_cnt;
  logic [8:0] obs_rd [4];

  int         exp_lat;
  logic [7:0] exp_b;
  logic [7:0] exp_addr;
  logic [2:0] exp_bit;
  int         exp_rd_cnt;
  logic [8:0] exp_rd0;
  logic [8:0] exp_rd1;

  logic [58:0] all_out;
  localparam logic [58:0] RESET_OUT = {1'b1, 58'd0};

  assign all_out = {in_ready, out_valid, ram_rd_en, ram_addr, ram_sfr, a_data, b_data,
                    bit_location, alu_op, instruction, psw_out, operand_addr};

  always #5 clk = ~clk;

  operand_fetch #(.RAM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction_in(instruction_in), .operand_in(operand_in), .src_mode(src_mode),
    .alu_op_in(alu_op_in), .acc_in(acc_in), .b_reg_in(b_reg_in), .psw_in(psw_in),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_sfr(ram_sfr), .ram_rdata(ram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .a_data(a_data), .b_data(b_data),
    .bit_location(bit_location), .alu_op(alu_op), .instruction(instruction),
    .psw_out(psw_out), .operand_addr(operand_addr)
  );

  // RAM/SFR port model: data one cycle after the strobe, garbage otherwise
  always @(posedge clk) begin
    if (ram_rd_en) ram_rdata <= ram_sfr ? sfrm[ram_addr] : iram[ram_addr];
    else           ram_rdata <= 8'($urandom);
  end

  // Reference model: what execute should see, from the addressing-mode rules
  function automatic void model(input logic [7:0] op, input logic [7:0] opnd,
                                input logic [2:0] mode, input logic [7:0] acc,
                                input logic [7:0] breg, input logic [7:0] psw);
    int bank, a, p;
    bank = (int'(psw) / 8) % 4;
    exp_lat = 1; exp_b = 0; exp_addr = 0; exp_bit = 0;
    exp_rd_cnt = 0; exp_rd0 = 0; exp_rd1 = 0;
    case (mode)
      3'd1: exp_b = opnd;
      3'd2: begin
        exp_addr = opnd;
        if (opnd == 8'hE0)      exp_b = acc;
        else if (opnd == 8'hF0) exp_b = breg;
        else if (opnd == 8'hD0) exp_b = psw;
        else begin
          exp_lat = 3; exp_rd_cnt = 1; exp_rd0 = {opnd >= 8'h80, opnd};
          exp_b = (opnd >= 8'h80) ? sfrm[opnd] : iram[opnd];
        end
      end
      3'd4: begin
        a = bank * 8 + int'(op) % 8;
        exp_lat = 3; exp_rd_cnt = 1; exp_rd0 = {1'b0, 8'(a)};
        exp_b = iram[a]; exp_addr = 8'(a);
      end
      3'd5: begin
        if (opnd < 8'h80) a = 32 + int'(opnd) / 8;
        else              a = (int'(opnd) / 8) * 8;
        exp_lat = 3; exp_rd_cnt = 1; exp_rd0 = {opnd >= 8'h80, 8'(a)};
        exp_b = (opnd >= 8'h80) ? sfrm[a] : iram[a];
        exp_addr = 8'(a); exp_bit = 3'(int'(opnd) % 8);
      end
      3'd3: begin
        a = bank * 8 + int'(op) % 2;
        p = int'(iram[a]);
        exp_lat = 5; exp_rd_cnt = 2;
        exp_rd0 = {1'b0, 8'(a)}; exp_rd1 = {1'b0, 8'(p)};
        exp_b = iram[p]; exp_addr = 8'(p);
      end
      default: exp_b = 0;
    endcase
  endfunction

  // Drive one instruction from a negedge, then watch reads until out_valid
  task automatic run_txn(input logic [7:0] op, input logic [7:0] opnd, input logic [2:0] mode,
                         input logic [3:0] aop, input logic [7:0] acc, input logic [7:0] breg,
                         input logic [7:0] psw);
    instruction_in = op; operand_in = opnd; src_mode = mode; alu_op_in = aop;
    acc_in = acc; b_reg_in = breg; psw_in = psw; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    instruction_in = 8'($urandom); operand_in = 8'($urandom); src_mode = 3'($urandom);
    alu_op_in = 4'($urandom); acc_in = 8'($urandom); b_reg_in = 8'($urandom);
    psw_in = 8'($urandom);
    obs_lat = -1; obs_rd_cnt = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (ram_rd_en) begin
        if (obs_rd_cnt < 4) obs_rd[obs_rd_cnt] = {ram_sfr, ram_addr};
        obs_rd_cnt++;
      end
      if (out_valid) begin
        obs_lat = n;
        break;
      end
    end
  endtask

  // Complete the output handshake and return to a negedge
  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (all_out !== RESET_OUT) begin errors++; $display("[TB] FAIL reset_outputs got=%h exp=%h", all_out, RESET_OUT); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (all_out !== RESET_OUT) begin errors++; $display("[TB] FAIL reset_idle got=%h exp=%h", all_out, RESET_OUT); end
  endtask

  task automatic test_imm();
    run_txn(8'h24, 8'h5A, 3'd1, 4'h3, 8'h11, 8'h00, 8'h00);
    checks++; if (obs_lat !== 1) begin errors++; $display("[TB] FAIL imm_latency got=%0d exp=1", obs_lat); end
    checks++; if ({a_data, b_data, operand_addr} !== 24'h115A00) begin errors++; $display("[TB] FAIL imm_data got=%h exp=115a00", {a_data, b_data, operand_addr}); end
    checks++; if ({instruction, alu_op} !== 12'h243) begin errors++; $display("[TB] FAIL imm_passthru got=%h exp=243", {instruction, alu_op}); end
    checks++; if (obs_rd_cnt !== 0) begin errors++; $display("[TB] FAIL imm_no_read got=%0d exp=0", obs_rd_cnt); end
    release_out();
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("[TB] FAIL imm_release got=%b exp=10", {in_ready, out_valid}); end
  endtask

  task automatic test_reg();
    iram[8'h13] = 8'h7E;
    run_txn(8'h2B, 8'h00, 3'd4, 4'h1, 8'h22, 8'h00, 8'h10);
    checks++; if (obs_lat !== 3) begin errors++; $display("[TB] FAIL reg_latency got=%0d exp=3", obs_lat); end
    checks++; if (obs_rd_cnt !== 1 || obs_rd[0] !== 9'h013) begin errors++; $display("[TB] FAIL reg_read got=%0d/%h exp=1/013", obs_rd_cnt, obs_rd[0]); end
    checks++; if ({b_data, operand_addr, psw_out} !== 24'h7E1310) begin errors++; $display("[TB] FAIL reg_data got=%h exp=7e1310", {b_data, operand_addr, psw_out}); end
    release_out();
  endtask

  task automatic test_ind();
    iram[8'h09] = 8'h90; iram[8'h90] = 8'h3C; sfrm[8'h90] = 8'hC3;
    run_txn(8'h27, 8'h00, 3'd3, 4'h2, 8'h33, 8'h00, 8'h08);
    checks++; if (obs_lat !== 5) begin errors++; $display("[TB] FAIL ind_latency got=%0d exp=5", obs_lat); end
    checks++; if (obs_rd_cnt !== 2 || obs_rd[0] !== 9'h009 || obs_rd[1] !== 9'h090) begin errors++; $display("[TB] FAIL ind_reads got=%0d/%h/%h exp=2/009/090", obs_rd_cnt, obs_rd[0], obs_rd[1]); end
    checks++; if ({b_data, operand_addr} !== 16'h3C90) begin errors++; $display("[TB] FAIL ind_data got=%h exp=3c90", {b_data, operand_addr}); end
    release_out();
  endtask

  task automatic test_bit();
    iram[8'h25] = 8'h81; sfrm[8'hE0] = 8'h4D;
    run_txn(8'hA2, 8'h2F, 3'd5, 4'h4, 8'h00, 8'h00, 8'h00);
    checks++; if (obs_rd_cnt !== 1 || obs_rd[0] !== 9'h025) begin errors++; $display("[TB] FAIL bit_low_read got=%0d/%h exp=1/025", obs_rd_cnt, obs_rd[0]); end
    checks++; if ({bit_location, b_data, operand_addr} !== {3'd7, 16'h8125}) begin errors++; $display("[TB] FAIL bit_low_data got=%h exp=%h", {bit_location, b_data, operand_addr}, {3'd7, 16'h8125}); end
    release_out();
    run_txn(8'hA2, 8'hE3, 3'd5, 4'h4, 8'h00, 8'h00, 8'h00);
    checks++; if (obs_rd_cnt !== 1 || obs_rd[0] !== 9'h1E0) begin errors++; $display("[TB] FAIL bit_sfr_read got=%0d/%h exp=1/1e0", obs_rd_cnt, obs_rd[0]); end
    checks++; if ({bit_location, b_data} !== {3'd3, 8'h4D}) begin errors++; $display("[TB] FAIL bit_sfr_data got=%h exp=%h", {bit_location, b_data}, {3'd3, 8'h4D}); end
    release_out();
  endtask

  task automatic test_dir_bypass_hold();
    run_txn(8'hE5, 8'hF0, 3'd2, 4'h5, 8'h66, 8'hA5, 8'h00);
    checks++; if (obs_lat !== 1 || obs_rd_cnt !== 0) begin errors++; $display("[TB] FAIL dir_b_bypass got=%0d/%0d exp=1/0", obs_lat, obs_rd_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if ({in_ready, out_valid, ram_rd_en, b_data, a_data, operand_addr} !== {3'b010, 24'hA566F0}) begin errors++; $display("[TB] FAIL dir_hold_%0d got=%h exp=%h", i, {in_ready, out_valid, ram_rd_en, b_data, a_data, operand_addr}, {3'b010, 24'hA566F0}); end
      @(negedge clk);
    end
    release_out();
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("[TB] FAIL dir_release got=%b exp=10", {in_ready, out_valid}); end
  endtask

  task automatic test_flush();
    iram[8'h09] = 8'h90;
    instruction_in = 8'h27; operand_in = 8'h00; src_mode = 3'd3; psw_in = 8'h08; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    checks++; if ({in_ready, out_valid, ram_rd_en} !== 3'b100) begin errors++; $display("[TB] FAIL flush_wt_ptr got=%b exp=100", {in_ready, out_valid, ram_rd_en}); end
    repeat (5) @(negedge clk);
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("[TB] FAIL flush_stays_idle got=%b exp=10", {in_ready, out_valid}); end
    run_txn(8'h24, 8'h77, 3'd1, 4'h6, 8'h12, 8'h00, 8'h00);
    checks++; if (obs_lat !== 1 || b_data !== 8'h77 || a_data !== 8'h12) begin errors++; $display("[TB] FAIL flush_then_imm got=%0d/%h/%h exp=1/77/12", obs_lat, b_data, a_data); end
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("[TB] FAIL flush_hold got=%b exp=10", {in_ready, out_valid}); end
    instruction_in = 8'h24; operand_in = 8'h99; src_mode = 3'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++; if ({in_ready, out_valid} !== 2'b10 || b_data === 8'h99) begin errors++; $display("[TB] FAIL flush_idle_accept got=%b/%h exp=10/not 99", {in_ready, out_valid}, b_data); end
  endtask

  task automatic test_reset_midflight();
    iram[8'h13] = 8'h55;
    instruction_in = 8'h2B; operand_in = 8'h00; src_mode = 3'd4; psw_in = 8'h10;
    acc_in = 8'hC7; alu_op_in = 4'h9; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (ram_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL midreset_rd_dat got=%b exp=1", ram_rd_en); end
    rst_n = 1'b0;
    #1;
    checks++; if (all_out !== RESET_OUT) begin errors++; $display("[TB] FAIL midreset_outputs got=%h exp=%h", all_out, RESET_OUT); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (all_out !== RESET_OUT) begin errors++; $display("[TB] FAIL midreset_aborted got=%h exp=%h", all_out, RESET_OUT); end
  endtask

  task automatic test_random();
    logic [7:0] op, opnd, acc, breg, psw;
    logic [2:0] mode;
    logic [3:0] aop;
    for (int i = 0; i < 256; i++) begin
      iram[i] = 8'($urandom);
      sfrm[i] = 8'($urandom);
    end
    for (int t = 0; t < 40; t++) begin
      op = 8'($urandom); opnd = 8'($urandom); acc = 8'($urandom); breg = 8'($urandom);
      psw = 8'($urandom); aop = 4'($urandom); mode = 3'($urandom_range(0, 7));
      if (mode == 3'd2 && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       opnd = 8'hE0;
          1:       opnd = 8'hF0;
          default: opnd = 8'hD0;
        endcase
      end
      model(op, opnd, mode, acc, breg, psw);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rnd%0d_ready got=%b exp=1", t, in_ready); end
      run_txn(op, opnd, mode, aop, acc, breg, psw);
      checks++; if (obs_lat !== exp_lat) begin errors++; $display("[TB] FAIL rnd%0d_latency mode=%0d got=%0d exp=%0d", t, mode, obs_lat, exp_lat); end
      checks++; if ({b_data, operand_addr, bit_location} !== {exp_b, exp_addr, exp_bit}) begin errors++; $display("[TB] FAIL rnd%0d_operand mode=%0d opnd=%h got=%h exp=%h", t, mode, opnd, {b_data, operand_addr, bit_location}, {exp_b, exp_addr, exp_bit}); end
      checks++; if ({a_data, psw_out, instruction, alu_op} !== {acc, psw, op, aop}) begin errors++; $display("[TB] FAIL rnd%0d_capture got=%h exp=%h", t, {a_data, psw_out, instruction, alu_op}, {acc, psw, op, aop}); end
      checks++; if (obs_rd_cnt !== exp_rd_cnt) begin errors++; $display("[TB] FAIL rnd%0d_read_count got=%0d exp=%0d", t, obs_rd_cnt, exp_rd_cnt); end
      if (exp_rd_cnt >= 1 && obs_rd_cnt >= 1) begin
        checks++; if (obs_rd[0] !== exp_rd0) begin errors++; $display("[TB] FAIL rnd%0d_read0 got=%h exp=%h", t, obs_rd[0], exp_rd0); end
      end
      if (exp_rd_cnt >= 2 && obs_rd_cnt >= 2) begin
        checks++; if (obs_rd[1] !== exp_rd1) begin errors++; $display("[TB] FAIL rnd%0d_read1 got=%h exp=%h", t, obs_rd[1], exp_rd1); end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      release_out();
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instruction_in = 8'h00; operand_in = 8'h00; src_mode = 3'd0; alu_op_in = 4'h0;
    acc_in = 8'h00; b_reg_in = 8'h00; psw_in = 8'h00;
    for (int i = 0; i < 256; i++) begin
      iram[i] = 8'(i ^ 8'h5C);
      sfrm[i] = 8'(i ^ 8'hA3);
    end
    $display("[TB] operand_fetch bench starting");
    test_reset();
    test_imm();
    test_reg();
    test_ind();
    test_bit();
    test_dir_bypass_hold();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
